// File: rtl/vga_timer_pkg.sv
// vga_timer_pkg: FSM states, timer register map and control bits.
// Snapshot states exist only with VGA_TIMER_CTRL_SNAP_EN.
package vga_timer_pkg;

  typedef enum logic [3:0] {
    IDLE,
    W_STOP,
    W_PERL,
    W_PERH,
    W_CLR,
    W_CTRL,
    RUN,
    ACK,
    ACK_WAIT,
    W_HALT
`ifdef VGA_TIMER_CTRL_SNAP_EN
    ,
    S_WR,
    S_RDL,
    S_RDH,
    S_CAP
`endif
  } state_e;

  localparam logic [2:0] STATUS  = 3'd0;
  localparam logic [2:0] CONTROL = 3'd1;
  localparam logic [2:0] PERL    = 3'd2;
  localparam logic [2:0] PERH    = 3'd3;
  localparam logic [2:0] SNAPL   = 3'd4;
  localparam logic [2:0] SNAPH   = 3'd5;

  localparam int ITO   = 0;
  localparam int CONT  = 1;
  localparam int START = 2;
  localparam int STOP  = 3;

  function automatic logic [15:0] ctl_word(
    input logic ito,
    input logic cont,
    input logic start,
    input logic stop
  );
    logic [15:0] w;
    w        = '0;
    w[ITO]   = ito;
    w[CONT]  = cont;
    w[START] = start;
    w[STOP]  = stop;
    return w;
  endfunction

endpackage

// File: rtl/vga_timer_ctrl_if.sv
// vga_timer_ctrl_if: Avalon-MM link from the controller to the timer.
// Single-beat, no waitrequest; readdata arrives one cycle after a read.
interface vga_timer_ctrl_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/vga_timer_bus_wr.sv
// vga_timer_bus_wr: registered single-beat Avalon write/read driver.
// Bus returns to idle whenever no command is presented.
module vga_timer_bus_wr (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_en,
  input  logic              cmd_wr,
  input  logic [2:0]        cmd_addr,
  input  logic [15:0]       cmd_data,
  vga_timer_ctrl_if.master  bus
);

  logic        cs_q, cs_d;
  logic        wn_q, wn_d;
  logic [2:0]  addr_q, addr_d;
  logic [15:0] data_q, data_d;

  always_comb begin
    cs_d   = cmd_en;
    wn_d   = !(cmd_en && cmd_wr);
    addr_d = cmd_en ? cmd_addr : 3'd0;
    data_d = (cmd_en && cmd_wr) ? cmd_data : 16'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cs_q   <= 1'b0;
      wn_q   <= 1'b1;
      addr_q <= 3'd0;
      data_q <= 16'd0;
    end else begin
      cs_q   <= cs_d;
      wn_q   <= wn_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign bus.chipselect = cs_q;
  assign bus.write_n    = wn_q;
  assign bus.address    = addr_q;
  assign bus.writedata  = data_q;

endmodule

// File: rtl/vga_timer_ctrl.sv
// vga_timer_ctrl: programs an Avalon interval timer and counts its ticks.
// Define VGA_TIMER_CTRL_SNAP_EN to add counter snapshot reads.
module vga_timer_ctrl
  import vga_timer_pkg::*;
#(
  parameter int TICK_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_start,
  input  logic              cfg_stop,
  input  logic [31:0]       cfg_period,
  input  logic              cfg_continuous,
  output logic [2:0]        tmr_address,
  output logic              tmr_chipselect,
  output logic              tmr_write_n,
  output logic [15:0]       tmr_writedata,
  input  logic [15:0]       tmr_readdata,
  input  logic              tmr_irq,
  output logic              busy,
  output logic              running,
  output logic              tick,
  output logic [TICK_W-1:0] tick_count
`ifdef VGA_TIMER_CTRL_SNAP_EN
  ,
  input  logic              snap_req,
  output logic [31:0]       snap_value,
  output logic              snap_valid
`endif
);

  vga_timer_ctrl_if tmr_bus ();

  state_e              state_q, state_d;
  logic [31:0]         per_q, per_d;
  logic                cont_q, cont_d;
  logic [TICK_W-1:0]   cnt_q, cnt_d;
  logic                tick_q, tick_d;
  logic                busy_q, busy_d;
  logic                run_q, run_d;
  logic                cmd_en, cmd_wr;
  logic [2:0]          cmd_addr;
  logic [15:0]         cmd_data;

`ifdef VGA_TIMER_CTRL_SNAP_EN
  logic [15:0] snap_lo_q, snap_lo_d;
  logic [31:0] snap_val_q, snap_val_d;
  logic        snap_vld_q, snap_vld_d;
  logic        irq_pend_q, irq_pend_d;
`else
  logic        rd_unused;
  assign rd_unused = ^tmr_bus.readdata;
`endif

  always_comb begin
    state_d = state_q;
    per_d   = per_q;
    cont_d  = cont_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
`ifdef VGA_TIMER_CTRL_SNAP_EN
    snap_lo_d  = snap_lo_q;
    snap_val_d = snap_val_q;
    snap_vld_d = 1'b0;
    irq_pend_d = irq_pend_q;
`endif
    unique case (state_q)
      IDLE, RUN: begin
        if (cfg_start) begin
          state_d = W_STOP;
          per_d   = (cfg_period == 32'd0) ? 32'd1 : cfg_period;
          cont_d  = cfg_continuous;
          cnt_d   = '0;
        end else if (state_q == RUN) begin
          // Stop outranks a coincident interrupt.
          if (cfg_stop) begin
            state_d = W_HALT;
          end else if (tmr_bus.irq) begin
            state_d = ACK;
            tick_d  = 1'b1;
            cnt_d   = cnt_q + 1'b1;
          end
`ifdef VGA_TIMER_CTRL_SNAP_EN
          else if (snap_req) begin
            state_d = S_WR;
          end
`endif
        end
      end
      W_STOP:   state_d = W_PERL;
      W_PERL:   state_d = W_PERH;
      W_PERH:   state_d = W_CLR;
      W_CLR:    state_d = W_CTRL;
      W_CTRL:   state_d = RUN;
      ACK:      state_d = cfg_stop ? W_HALT : ACK_WAIT;
      ACK_WAIT: begin
        if (cfg_stop)    state_d = W_HALT;
        else if (cont_q) state_d = RUN;
        else             state_d = IDLE;
      end
      W_HALT:   state_d = IDLE;
`ifdef VGA_TIMER_CTRL_SNAP_EN
      S_WR: begin
        state_d    = S_RDL;
        irq_pend_d = irq_pend_q | tmr_bus.irq;
      end
      S_RDL: begin
        state_d    = S_RDH;
        irq_pend_d = irq_pend_q | tmr_bus.irq;
      end
      S_RDH: begin
        state_d    = S_CAP;
        snap_lo_d  = tmr_bus.readdata;
        irq_pend_d = irq_pend_q | tmr_bus.irq;
      end
      S_CAP: begin
        snap_val_d = {tmr_bus.readdata, snap_lo_q};
        snap_vld_d = 1'b1;
        irq_pend_d = 1'b0;
        if (irq_pend_q || tmr_bus.irq) begin
          state_d = ACK;
          tick_d  = 1'b1;
          cnt_d   = cnt_q + 1'b1;
        end else begin
          state_d = RUN;
        end
      end
`endif
      default:  state_d = IDLE;
    endcase
    busy_d = !(state_d inside {IDLE, RUN});
    run_d  = state_d inside {RUN, ACK, ACK_WAIT};
  end

  // Bus command follows the state being entered, so it lands with it.
  always_comb begin
    cmd_en   = 1'b0;
    cmd_wr   = 1'b1;
    cmd_addr = STATUS;
    cmd_data = '0;
    unique case (state_d)
      W_STOP, W_HALT: begin
        cmd_en   = 1'b1;
        cmd_addr = CONTROL;
        cmd_data = ctl_word(1'b0, 1'b0, 1'b0, 1'b1);
      end
      W_PERL: begin
        cmd_en   = 1'b1;
        cmd_addr = PERL;
        cmd_data = per_d[15:0];
      end
      W_PERH: begin
        cmd_en   = 1'b1;
        cmd_addr = PERH;
        cmd_data = per_d[31:16];
      end
      W_CLR, ACK: begin
        cmd_en   = 1'b1;
        cmd_addr = STATUS;
      end
      W_CTRL: begin
        cmd_en   = 1'b1;
        cmd_addr = CONTROL;
        cmd_data = ctl_word(1'b1, cont_d, 1'b1, 1'b0);
      end
`ifdef VGA_TIMER_CTRL_SNAP_EN
      S_WR: begin
        cmd_en   = 1'b1;
        cmd_addr = SNAPL;
      end
      S_RDL: begin
        cmd_en   = 1'b1;
        cmd_wr   = 1'b0;
        cmd_addr = SNAPL;
      end
      S_RDH: begin
        cmd_en   = 1'b1;
        cmd_wr   = 1'b0;
        cmd_addr = SNAPH;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      per_q   <= '0;
      cont_q  <= 1'b0;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      busy_q  <= 1'b0;
      run_q   <= 1'b0;
`ifdef VGA_TIMER_CTRL_SNAP_EN
      snap_lo_q  <= '0;
      snap_val_q <= '0;
      snap_vld_q <= 1'b0;
      irq_pend_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      per_q   <= per_d;
      cont_q  <= cont_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      busy_q  <= busy_d;
      run_q   <= run_d;
`ifdef VGA_TIMER_CTRL_SNAP_EN
      snap_lo_q  <= snap_lo_d;
      snap_val_q <= snap_val_d;
      snap_vld_q <= snap_vld_d;
      irq_pend_q <= irq_pend_d;
`endif
    end
  end

  vga_timer_bus_wr u_bus (
    .clk      (clk),
    .reset    (reset),
    .cmd_en   (cmd_en),
    .cmd_wr   (cmd_wr),
    .cmd_addr (cmd_addr),
    .cmd_data (cmd_data),
    .bus      (tmr_bus)
  );

  assign tmr_bus.readdata = tmr_readdata;
  assign tmr_bus.irq      = tmr_irq;
  assign tmr_address      = tmr_bus.address;
  assign tmr_chipselect   = tmr_bus.chipselect;
  assign tmr_write_n      = tmr_bus.write_n;
  assign tmr_writedata    = tmr_bus.writedata;

  assign busy       = busy_q;
  assign running    = run_q;
  assign tick       = tick_q;
  assign tick_count = cnt_q;
`ifdef VGA_TIMER_CTRL_SNAP_EN
  assign snap_value = snap_val_q;
  assign snap_valid = snap_vld_q;
`endif

endmodule

// File: tb/tb_vga_timer_ctrl.sv
// tb_vga_timer_ctrl: directed bench with a write scoreboard.
// Snapshot checks build only with VGA_TIMER_CTRL_SNAP_EN.
module tb_vga_timer_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_start;
  logic        cfg_stop;
  logic [31:0] cfg_period;
  logic        cfg_continuous;
  logic        busy;
  logic        running;
  logic        tick;
  logic [15:0] tick_count;
`ifdef VGA_TIMER_CTRL_SNAP_EN
  logic        snap_req;
  logic [31:0] snap_value;
  logic        snap_valid;
`endif

  vga_timer_ctrl_if bus ();

  int total = 0;
  int bad = 0;
  int tick_seen = 0;
  logic [18:0] exp_q[$];
  logic [18:0] exp_w;

  always #5 clk = ~clk;

  vga_timer_ctrl #(.TICK_W(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .cfg_start      (cfg_start),
    .cfg_stop       (cfg_stop),
    .cfg_period     (cfg_period),
    .cfg_continuous (cfg_continuous),
    .tmr_address    (bus.address),
    .tmr_chipselect (bus.chipselect),
    .tmr_write_n    (bus.write_n),
    .tmr_writedata  (bus.writedata),
    .tmr_readdata   (bus.readdata),
    .tmr_irq        (bus.irq),
    .busy           (busy),
    .running        (running),
    .tick           (tick),
    .tick_count     (tick_count)
`ifdef VGA_TIMER_CTRL_SNAP_EN
    ,
    .snap_req       (snap_req),
    .snap_value     (snap_value),
    .snap_valid     (snap_valid)
`endif
  );

  // Timer slave: snapshot registers hold 0x00012345.
  always @(posedge clk) begin
    if (bus.chipselect && bus.write_n && bus.address == 3'd4)
      bus.readdata <= 16'h2345;
    else if (bus.chipselect && bus.write_n && bus.address == 3'd5)
      bus.readdata <= 16'h0001;
    else
      bus.readdata <= 16'h0000;
  end

  always @(negedge clk) begin
    if (tick) tick_seen++;
    if (bus.chipselect && !bus.write_n) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL bus_write: unexpected addr=%0d data=%h",
                 bus.address, bus.writedata);
      end else begin
        exp_w = exp_q.pop_front();
        if ({bus.address, bus.writedata} !== exp_w) begin
          bad++;
          $display("FAIL bus_write: got addr=%0d data=%h want addr=%0d data=%h",
                   bus.address, bus.writedata, exp_w[18:16], exp_w[15:0]);
        end
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic start(input logic [31:0] p, input logic c);
    cfg_start      = 1'b1;
    cfg_period     = p;
    cfg_continuous = c;
    step();
    cfg_start = 1'b0;
  endtask

  task automatic drain(input string nm);
    @(negedge clk);
    #1;
    check(nm, exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    cfg_start      = 1'b0;
    cfg_stop       = 1'b0;
    cfg_period     = '0;
    cfg_continuous = 1'b0;
    bus.irq        = 1'b0;
`ifdef VGA_TIMER_CTRL_SNAP_EN
    snap_req       = 1'b0;
`endif
    step(2);
    check("rst_busy", busy, 0);
    check("rst_running", running, 0);
    check("rst_tick", tick, 0);
    check("rst_count", tick_count, 0);
    check("rst_cs", bus.chipselect, 0);
    check("rst_write_n", bus.write_n, 1);
    check("rst_addr", bus.address, 0);
    check("rst_data", bus.writedata, 0);
    reset = 1'b0;
    step();

    // Programming sequence, continuous
    wr(1, 16'h0008); wr(2, 16'hC34F); wr(3, 16'h0000);
    wr(0, 16'h0000); wr(1, 16'h0007);
    start(32'h0000C34F, 1'b1);
    check("prog_busy", busy, 1);
    step(4);
    check("ctrl_not_running", running, 0);
    drain("prog_writes");
    step();
    check("run_running", running, 1);
    check("run_busy", busy, 0);

    // Three single-cycle interrupts
    for (int i = 0; i < 3; i++) begin
      wr(0, 16'h0000);
      bus.irq = 1'b1;
      step();
      bus.irq = 1'b0;
      check("irq_tick", tick, 1);
      step();
      check("tick_one_cycle", tick, 0);
      step();
    end
    check("tick_count3", tick_count, 3);
    check("tick_seen3", tick_seen, 3);

    // Interrupt held for two cycles counts once
    wr(0, 16'h0000);
    bus.irq = 1'b1;
    step(2);
    bus.irq = 1'b0;
    step(2);
    check("held_count", tick_count, 4);
    check("held_seen", tick_seen, 4);
    drain("held_writes");

`ifdef VGA_TIMER_CTRL_SNAP_EN
    wr(4, 16'h0000);
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    step(3);
    check("snap_early", snap_valid, 0);
    step();
    check("snap_valid", snap_valid, 1);
    check("snap_value", snap_value, 32'h00012345);
    check("snap_back_run", running, 1);
    step();
    check("snap_pulse", snap_valid, 0);
    drain("snap_writes");
`endif

    // One-shot restart from RUN
    wr(1, 16'h0008); wr(2, 16'h0002); wr(3, 16'h0001);
    wr(0, 16'h0000); wr(1, 16'h0005);
    start(32'h00010002, 1'b0);
    check("start_clears_count", tick_count, 0);
    step(5);
    check("oneshot_running", running, 1);
    wr(0, 16'h0000);
    bus.irq = 1'b1;
    step();
    bus.irq = 1'b0;
    step(2);
    check("oneshot_count", tick_count, 1);
    check("oneshot_idle_run", running, 0);
    check("oneshot_idle_busy", busy, 0);
    cfg_stop = 1'b1;
    step();
    cfg_stop = 1'b0;
    step(3);
    check("stop_in_idle", busy, 0);
    drain("oneshot_quiet");

    // Stop and irq together: stop wins
    wr(1, 16'h0008); wr(2, 16'h0010); wr(3, 16'h0000);
    wr(0, 16'h0000); wr(1, 16'h0007);
    start(32'h00000010, 1'b1);
    step(5);
    wr(0, 16'h0000);
    bus.irq = 1'b1;
    step();
    bus.irq = 1'b0;
    step(2);
    wr(1, 16'h0008);
    cfg_stop = 1'b1;
    bus.irq  = 1'b1;
    step();
    cfg_stop = 1'b0;
    bus.irq  = 1'b0;
    check("halt_no_tick", tick, 0);
    check("halt_running", running, 0);
    check("halt_busy", busy, 1);
    step();
    check("halt_idle", busy, 0);
    check("halt_count", tick_count, 1);
    drain("halt_writes");

    // Zero period clamps; start during W_PERH ignored
    wr(1, 16'h0008); wr(2, 16'h0001); wr(3, 16'h0000);
    wr(0, 16'h0000); wr(1, 16'h0007);
    start(32'h00000000, 1'b1);
    step(2);
    cfg_start      = 1'b1;
    cfg_period     = 32'h00000099;
    cfg_continuous = 1'b0;
    step();
    cfg_start = 1'b0;
    step(2);
    check("clamp_running", running, 1);
    drain("clamp_writes");

    // Reset during W_PERH
    wr(1, 16'h0008); wr(2, 16'h0006); wr(3, 16'h0005);
    start(32'h00050006, 1'b0);
    step(2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_cs", bus.chipselect, 0);
    check("abort_write_n", bus.write_n, 1);
    check("abort_addr", bus.address, 0);
    check("abort_data", bus.writedata, 0);
    check("abort_busy", busy, 0);
    check("abort_running", running, 0);
    step(3);
    drain("abort_quiet");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
